// File: rtl/park_pkg.sv
// Shared definitions for the single-gate parking controller: FSM state
// encoding, last-served side encoding and default sizing constants.
package park_pkg;

   typedef enum logic [1:0] {
      PARK_IDLE     = 2'b00,
      PARK_OPEN_IN  = 2'b01,
      PARK_OPEN_OUT = 2'b10,
      PARK_CLOSE    = 2'b11
   } park_state_t;

   typedef enum logic {
      SIDE_ENTRY = 1'b0,
      SIDE_EXIT  = 1'b1
   } park_side_t;

   localparam int PARK_DEF_CAPACITY   = 8;
   localparam int PARK_DEF_CNT_W      = 4;
   localparam int PARK_DEF_GATE_TICKS = 5;

endpackage

// File: rtl/park_gate_timer.sv
// Gate-open timer: counts tick pulses after a start and flags done on the
// GATE_TICKS-th tick. The counter clears itself when done fires.
module park_gate_timer
   import park_pkg::*;
#(
   parameter int GATE_TICKS = PARK_DEF_GATE_TICKS
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic start,
   input  logic tick,
   output logic done
);

   logic [7:0] tick_cnt_r;
   logic       running_r;
   logic       at_last_s;

   assign at_last_s = (tick_cnt_r == 8'(GATE_TICKS - 1));
   assign done      = running_r & tick & at_last_s;

   // Tick counter: restarted by start, advanced by tick, cleared on done
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_cnt_r <= 8'd0;
         running_r  <= 1'b0;
      end else if (start) begin
         tick_cnt_r <= 8'd0;
         running_r  <= 1'b1;
      end else if (running_r && tick) begin
         if (at_last_s) begin
            tick_cnt_r <= 8'd0;
            running_r  <= 1'b0;
         end else begin
            tick_cnt_r <= tick_cnt_r + 8'd1;
            running_r  <= 1'b1;
         end
      end else begin
         tick_cnt_r <= tick_cnt_r;
         running_r  <= running_r;
      end
   end

endmodule

// File: rtl/park_gate_ctrl.sv
// Single-gate parking lot controller: round-robin arbitration of entry and
// exit requests onto one barrier, occupancy tracking with full/empty flags
// and a one-cycle full_pulse for the lot-full light sequencer.
// Optional build macro PARK_REJECT_CNT_EN adds a saturating reject_cnt
// output counting full-lot entry rejections.
module park_gate_ctrl
   import park_pkg::*;
#(
   parameter int CAPACITY   = PARK_DEF_CAPACITY,
   parameter int CNT_W      = PARK_DEF_CNT_W,
   parameter int GATE_TICKS = PARK_DEF_GATE_TICKS
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             tick,
   input  logic             entry_req,
   input  logic             exit_req,
   output logic             entry_grant,
   output logic             exit_grant,
   output logic             gate_open,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             full_pulse
`ifdef PARK_REJECT_CNT_EN
   ,
   output logic [7:0]       reject_cnt
`endif
);

   park_state_t      state_r, state_nxt;
   park_side_t       last_r, last_nxt;
   logic [CNT_W-1:0] count_r, count_nxt;
   logic             gate_open_r, gate_open_nxt;
   logic             entry_grant_r, entry_grant_nxt;
   logic             exit_grant_r, exit_grant_nxt;
   logic             full_r, full_nxt;
   logic             empty_r, empty_nxt;
   logic             full_pulse_r, full_pulse_nxt;
   logic             rej_prev_r;
   logic             entry_ok_s, exit_ok_s;
   logic             rej_s, rej_rise_s, cap_pulse_s;
   logic             start_s, done_s;

   park_gate_timer #(
      .GATE_TICKS (GATE_TICKS)
   ) u_timer (
      .CLK   (CLK),
      .RST_N (RST_N),
      .start (start_s),
      .tick  (tick),
      .done  (done_s)
   );

   assign entry_ok_s = entry_req & ~full_r;
   assign exit_ok_s  = exit_req & ~empty_r;

   // Next-state, arbitration and occupancy update
   always_comb begin
      state_nxt       = state_r;
      last_nxt        = last_r;
      count_nxt       = count_r;
      gate_open_nxt   = gate_open_r;
      entry_grant_nxt = 1'b0;
      exit_grant_nxt  = 1'b0;
      cap_pulse_s     = 1'b0;
      rej_s           = 1'b0;
      start_s         = 1'b0;
      case (state_r)
         PARK_IDLE: begin
            if (entry_ok_s && (!exit_ok_s || (last_r == SIDE_EXIT))) begin
               state_nxt       = PARK_OPEN_IN;
               last_nxt        = SIDE_ENTRY;
               count_nxt       = count_r + CNT_W'(1);
               gate_open_nxt   = 1'b1;
               entry_grant_nxt = 1'b1;
               start_s         = 1'b1;
               cap_pulse_s     = (count_r == CNT_W'(CAPACITY - 1));
            end else if (exit_ok_s) begin
               state_nxt      = PARK_OPEN_OUT;
               last_nxt       = SIDE_EXIT;
               count_nxt      = count_r - CNT_W'(1);
               gate_open_nxt  = 1'b1;
               exit_grant_nxt = 1'b1;
               start_s        = 1'b1;
            end else begin
               // No grant: a pending entry against a full lot is a rejection
               rej_s = entry_req & full_r;
            end
         end
         PARK_OPEN_IN, PARK_OPEN_OUT: begin
            if (done_s) begin
               state_nxt     = PARK_CLOSE;
               gate_open_nxt = 1'b0;
            end else begin
               state_nxt = state_r;
            end
         end
         PARK_CLOSE: begin
            state_nxt     = PARK_IDLE;
            gate_open_nxt = 1'b0;
         end
         default: begin
            state_nxt     = PARK_IDLE;
            gate_open_nxt = 1'b0;
         end
      endcase
      rej_rise_s     = rej_s & ~rej_prev_r;
      full_pulse_nxt = cap_pulse_s | rej_rise_s;
      full_nxt       = (count_nxt == CNT_W'(CAPACITY));
      empty_nxt      = (count_nxt == CNT_W'(0));
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r       <= PARK_IDLE;
         last_r        <= SIDE_EXIT;
         count_r       <= '0;
         gate_open_r   <= 1'b0;
         entry_grant_r <= 1'b0;
         exit_grant_r  <= 1'b0;
         full_r        <= 1'b0;
         empty_r       <= 1'b1;
         full_pulse_r  <= 1'b0;
         rej_prev_r    <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         last_r        <= last_nxt;
         count_r       <= count_nxt;
         gate_open_r   <= gate_open_nxt;
         entry_grant_r <= entry_grant_nxt;
         exit_grant_r  <= exit_grant_nxt;
         full_r        <= full_nxt;
         empty_r       <= empty_nxt;
         full_pulse_r  <= full_pulse_nxt;
         rej_prev_r    <= rej_s;
      end
   end

   assign entry_grant = entry_grant_r;
   assign exit_grant  = exit_grant_r;
   assign gate_open   = gate_open_r;
   assign count       = count_r;
   assign full        = full_r;
   assign empty       = empty_r;
   assign full_pulse  = full_pulse_r;

`ifdef PARK_REJECT_CNT_EN
   logic [7:0] reject_cnt_r;

   // Saturating tally of rejection pulses (capacity-reached pulse excluded)
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         reject_cnt_r <= 8'd0;
      end else if (rej_rise_s && (reject_cnt_r != 8'hFF)) begin
         reject_cnt_r <= reject_cnt_r + 8'd1;
      end else begin
         reject_cnt_r <= reject_cnt_r;
      end
   end

   assign reject_cnt = reject_cnt_r;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Self-checking bench for park_gate_ctrl (CAPACITY=8, GATE_TICKS=5).
// Expected grant results are queued when requests are driven; a negedge
// monitor pops and compares them whenever a grant pulse appears.
module tb_park_gate_ctrl;

   localparam int CAP = 8;
   localparam int GT  = 5;

   logic       CLK       = 1'b0;
   logic       RST_N     = 1'b0;
   logic       tick      = 1'b0;
   logic       entry_req = 1'b0;
   logic       exit_req  = 1'b0;
   logic       entry_grant, exit_grant, gate_open, full, empty, full_pulse;
   logic [3:0] count;
`ifdef PARK_REJECT_CNT_EN
   logic [7:0] reject_cnt;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       is_entry;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       fpulse;
   } exp_t;

   exp_t exp_q[$];
   int   model_count = 0;
   int   tick_div    = 0;
   int   open_ticks  = 0;
   int   low_gap     = 100;
   logic prev_gate   = 1'b0;

   park_gate_ctrl #(.CAPACITY(CAP), .CNT_W(4), .GATE_TICKS(GT)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .tick        (tick),
      .entry_req   (entry_req),
      .exit_req    (exit_req),
      .entry_grant (entry_grant),
      .exit_grant  (exit_grant),
      .gate_open   (gate_open),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .full_pulse  (full_pulse)
`ifdef PARK_REJECT_CNT_EN
      ,
      .reject_cnt  (reject_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   // tick: one cycle high out of every three
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         tick = (tick_div == 2);
         tick_div = (tick_div == 2) ? 0 : tick_div + 1;
      end
   end

   // Scoreboard monitor: grant results, gate-open length, no back-to-back reopen
   initial begin
      exp_t e;
      logic [8:0] obs_v, exp_v;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_gate  = 1'b0;
            open_ticks = 0;
            low_gap    = 100;
         end else begin
            if (entry_grant || exit_grant) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL grant_unexpected: entry_grant=%0b exit_grant=%0b count=%0d, required no grant",
                           entry_grant, exit_grant, count);
               end else begin
                  e = exp_q.pop_front();
                  obs_v = {entry_grant, exit_grant, count, full, empty, full_pulse};
                  exp_v = {e.is_entry, ~e.is_entry, e.cnt, e.full, e.empty, e.fpulse};
                  if (obs_v !== exp_v) begin
                     bad++;
                     $display("FAIL grant_result {eg,xg,count,full,empty,fpulse}: got %b required %b", obs_v, exp_v);
                  end
               end
            end
            if (gate_open && tick) open_ticks++;
            if (gate_open && !prev_gate) begin
               total++;
               if (low_gap < 2) begin
                  bad++;
                  $display("FAIL gate_reopen: closed for %0d cycles, required >= 2", low_gap);
               end
            end
            if (!gate_open && prev_gate) begin
               total++;
               if (open_ticks != GT) begin
                  bad++;
                  $display("FAIL gate_open_ticks: got %0d required %0d", open_ticks, GT);
               end
               open_ticks = 0;
               low_gap    = 0;
            end
            if (!gate_open) low_gap++;
            prev_gate = gate_open;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_exp(input bit is_entry);
      exp_t e;
      if (is_entry) model_count++;
      else model_count--;
      e.is_entry = is_entry;
      e.cnt      = 4'(model_count);
      e.full     = (model_count == CAP);
      e.empty    = (model_count == 0);
      e.fpulse   = is_entry && (model_count == CAP);
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input int max_cyc, output int lat);
      int i = 0;
      lat = 0;
      while (lat == 0 && i < max_cyc) begin
         @(posedge CLK);
         #1;
         i++;
         if (entry_grant || exit_grant) lat = i;
      end
   endtask

   task automatic wait_idle();
      int i = 0;
      while (gate_open && i < 100) begin
         @(posedge CLK);
         #1;
         i++;
      end
      total++;
      if (gate_open) begin
         bad++;
         $display("FAIL wait_idle: gate_open=%0b after %0d cycles, required 0", gate_open, i);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic serve(input bit is_entry, output int lat);
      @(posedge CLK);
      #1;
      if (is_entry) entry_req = 1'b1;
      else exit_req = 1'b1;
      wait_grant(10, lat);
      entry_req = 1'b0;
      exit_req  = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset();
      repeat (2) @(posedge CLK);
      #1;
      total++;
      if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", count); end
      total++;
      if ({gate_open, entry_grant, exit_grant, full_pulse} !== 4'b0000) begin
         bad++; $display("FAIL reset_outputs {gate,eg,xg,fp}: got %b required 0000",
                         {gate_open, entry_grant, exit_grant, full_pulse});
      end
      total++;
      if ({full, empty} !== 2'b01) begin bad++; $display("FAIL reset_flags {full,empty}: got %b required 01", {full, empty}); end
`ifdef PARK_REJECT_CNT_EN
      total++;
      if (reject_cnt !== 8'd0) begin bad++; $display("FAIL reset_reject_cnt: got %0d required 0", reject_cnt); end
`endif
      RST_N = 1'b1;
   endtask

   task automatic test_single_entry();
      int lat;
      push_exp(1'b1);
      serve(1'b1, lat);
      total++;
      if (lat != 1) begin bad++; $display("FAIL single_latency: got %0d required 1", lat); end
      total++;
      if ({count, empty} !== {4'd1, 1'b0}) begin bad++; $display("FAIL single_count: got %0d/%0b required 1/0", count, empty); end
   endtask

   task automatic test_fill();
      int lat;
      for (int k = 2; k <= CAP; k++) begin
         push_exp(1'b1);
         serve(1'b1, lat);
         total++;
         if (lat != 1) begin bad++; $display("FAIL fill_latency entry %0d: got %0d required 1", k, lat); end
      end
      total++;
      if ({count, full} !== {4'd8, 1'b1}) begin bad++; $display("FAIL fill_full: got %0d/%0b required 8/1", count, full); end
   endtask

   task automatic test_reject();
      int pulses = 0, grants = 0, opens = 0;
      @(posedge CLK);
      #1;
      entry_req = 1'b1;
      repeat (12) begin
         @(posedge CLK);
         #1;
         if (full_pulse) pulses++;
         if (entry_grant || exit_grant) grants++;
         if (gate_open) opens++;
      end
      total++;
      if (pulses != 1) begin bad++; $display("FAIL reject_pulses: got %0d required 1", pulses); end
      total++;
      if (grants != 0 || opens != 0) begin bad++; $display("FAIL reject_grant: grants=%0d opens=%0d required 0/0", grants, opens); end
      total++;
      if (count !== 4'd8) begin bad++; $display("FAIL reject_count: got %0d required 8", count); end
`ifdef PARK_REJECT_CNT_EN
      total++;
      if (reject_cnt !== 8'd1) begin bad++; $display("FAIL reject_cnt: got %0d required 1", reject_cnt); end
`endif
   endtask

   task automatic test_full_exit();
      int lat, lat2;
      push_exp(1'b0);
      push_exp(1'b1);
      exit_req = 1'b1;
      wait_grant(10, lat);
      exit_req = 1'b0;
      total++;
      if (lat != 1 || exit_grant !== 1'b1) begin bad++; $display("FAIL fullexit_exit: lat=%0d exit_grant=%0b required 1/1", lat, exit_grant); end
      wait_grant(60, lat2);
      entry_req = 1'b0;
      total++;
      if (lat2 == 0 || entry_grant !== 1'b1) begin bad++; $display("FAIL fullexit_pending_entry: lat=%0d entry_grant=%0b required grant", lat2, entry_grant); end
      wait_idle();
      total++;
      if (count !== 4'd8) begin bad++; $display("FAIL fullexit_count: got %0d required 8", count); end
`ifdef PARK_REJECT_CNT_EN
      total++;
      if (reject_cnt !== 8'd1) begin bad++; $display("FAIL fullexit_reject_cnt: got %0d required 1", reject_cnt); end
`endif
   endtask

   task automatic test_drain(input int n);
      int lat;
      for (int k = 0; k < n; k++) begin
         push_exp(1'b0);
         serve(1'b0, lat);
         total++;
         if (lat != 1) begin bad++; $display("FAIL drain_latency exit %0d: got %0d required 1", k, lat); end
      end
   endtask

   task automatic test_round_robin();
      int lat, lat2;
      push_exp(1'b1);
      push_exp(1'b0);
      @(posedge CLK);
      #1;
      entry_req = 1'b1;
      exit_req  = 1'b1;
      wait_grant(10, lat);
      total++;
      if (lat != 1 || entry_grant !== 1'b1) begin bad++; $display("FAIL rr_first: lat=%0d entry_grant=%0b required 1/1", lat, entry_grant); end
      entry_req = 1'b0;
      wait_grant(60, lat2);
      exit_req = 1'b0;
      total++;
      if (lat2 == 0 || exit_grant !== 1'b1) begin bad++; $display("FAIL rr_second: lat=%0d exit_grant=%0b required grant", lat2, exit_grant); end
      wait_idle();
      total++;
      if (count !== 4'd4) begin bad++; $display("FAIL rr_count: got %0d required 4", count); end
   endtask

   task automatic test_async_reset();
      int lat;
      push_exp(1'b1);
      @(posedge CLK);
      #1;
      entry_req = 1'b1;
      wait_grant(10, lat);
      entry_req = 1'b0;
      total++;
      if ({count, gate_open} !== {4'd3, 1'b1}) begin bad++; $display("FAIL areset_pre: count=%0d gate=%0b required 3/1", count, gate_open); end
      repeat (3) @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      total++;
      if ({gate_open, count, empty, full} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL areset_async {gate,count,empty,full}: got %b required 0000010",
                         {gate_open, count, empty, full});
      end
      model_count = 0;
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL areset_queue: %0d pending, required 0", exp_q.size()); end
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic test_empty_exit();
      int grants = 0, opens = 0;
      @(posedge CLK);
      #1;
      exit_req = 1'b1;
      repeat (20) begin
         @(posedge CLK);
         #1;
         if (entry_grant || exit_grant) grants++;
         if (gate_open) opens++;
      end
      exit_req = 1'b0;
      total++;
      if (grants != 0 || opens != 0) begin bad++; $display("FAIL empty_exit: grants=%0d opens=%0d required 0/0", grants, opens); end
      total++;
      if ({count, empty} !== {4'd0, 1'b1}) begin bad++; $display("FAIL empty_count: got %0d/%0b required 0/1", count, empty); end
   endtask

   task automatic test_resume();
      int lat;
      push_exp(1'b1);
      serve(1'b1, lat);
      total++;
      if (lat != 1) begin bad++; $display("FAIL resume_latency: got %0d required 1", lat); end
      total++;
      if (count !== 4'd1) begin bad++; $display("FAIL resume_count: got %0d required 1", count); end
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_fill();
      test_reject();
      test_full_exit();
      test_drain(4);
      test_round_robin();
      test_drain(2);
      test_async_reset();
      test_empty_exit();
      test_resume();
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expect: %0d grants never seen", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
